buttons_debounce: RTL and testbench
===================================

# buttons_debounce

Input-side counterpart of the board LED driver: samples N raw push-button pins, synchronizes them into the `clk` domain, debounces each one with a per-button stability counter, and reports clean levels, one-cycle press/release pulses and a per-button toggle bit. It sits between the button pins and user logic; `toggle` can drive the LED outputs directly.

## Interface
- `N`, default 4: number of buttons.
- `DEBOUNCE`, default 120000: consecutive cycles a new synchronized level must persist before it is accepted (10 ms at 12 MHz); legal range ≥ 1.
- `ACTIVE_LOW`, default 1: 1 means a pressed pin reads 0.
- `clk`  input  1  system clock.
- `rstn`  input  1  asynchronous, active-low reset.
- `btn`  input  N  raw button pins, asynchronous to `clk`.
- `state`  output  N  debounced level, 1 = pressed.
- `press`  output  N  one-cycle pulse when `state[i]` goes 0→1.
- `release`  output  N  one-cycle pulse when `state[i]` goes 1→0.
- `toggle`  output  N  flips on every press.

## Operation
- Polarity: `lvl[i] = btn[i] ^ ACTIVE_LOW`, so 1 means pressed. Everything downstream works on `lvl`.
- Synchronizer: two flops, `s0`→`s1`, per button. Both reset to 0 (released).
- Counter: `cnt` per button, width `$clog2(DEBOUNCE+1)`, reset 0.
  - `s1 == state`: `cnt` ← 0.
  - `s1 != state` and `cnt == DEBOUNCE-1`: `state` ← `s1`, `cnt` ← 0, fire the press or release pulse.
  - Otherwise: `cnt` ← `cnt + 1`.
  - `cnt` never exceeds `DEBOUNCE-1` and does not wrap.
- Glitch rejection: if `s1` returns to `state` before the count completes, `cnt` clears and no event fires. Any glitch shorter than `DEBOUNCE` synchronized cycles is invisible.
- Pulses: `press` and `release` are registered, high for exactly one cycle, and coincide with the first cycle `state` shows its new value. `press[i]` and `release[i]` are never high together.
- Toggle: `toggle[i]` flips on the same edge that sets `press[i]`.
- Independence: buttons are fully independent. Simultaneous events on different bits are all reported in the same cycle.
- Reset:
  - Applies immediately regardless of `clk`.
  - All outputs, synchronizers and counters go to 0.
  - A button held through reset is reported as a press `2+DEBOUNCE` cycles after `rstn` deasserts.
  - Reset mid-count discards the partial count and emits no pulse.

## Timing
- Reset values: `state`=0, `press`=0, `release`=0, `toggle`=0.
- Latency from the first `clk` edge that samples a new stable `lvl` to the `state`/pulse update: exactly `2 + DEBOUNCE` rising edges.
- Minimum spacing between two accepted events on one button: `DEBOUNCE` cycles.
- With `DEBOUNCE=1`, a new level is accepted after one cycle of mismatch, so total latency is 3 cycles.
- No handshake: pulses are fire-and-forget and must be consumed in their single high cycle.

## Structure
- Sub-module `debounce_cell`: one button, containing the synchronizer, counter, state, pulse and toggle logic. Parameters are `DEBOUNCE` and `ACTIVE_LOW`.
- Top level: a generate loop of N cells; no shared logic between cells.
- Shared package `buttons_pkg`:
  - `CLK_HZ` = 12_000_000.
  - `DEBOUNCE_MS` = 10.
  - Derived default `DEBOUNCE_CYCLES`.
  - Simulation override `DEBOUNCE_SIM` = 4.

## Test plan
All scenarios use `N=4`, `DEBOUNCE=4`, `ACTIVE_LOW=1`.
- Reset with all pins high → `state`/`press`/`release`/`toggle` = 0 and stay 0 for 20 cycles.
- `btn[0]` driven low and held → `state[0]`=1 and `press[0]`=1 exactly 6 edges later, `press[0]` for one cycle, `toggle[0]`=1. Release → `release[0]` 6 edges later, `toggle[0]` stays 1.
- `btn[1]` low for 3 cycles, then high → no pulse, `state[1]` stays 0. Low for 4 cycles → press accepted.
- Bouncing pattern on `btn[2]` (low 2, high 1, low 2, high 1, then low steady) → exactly one `press[2]`, 6 edges after the steady low begins.
- `btn[0]` and `btn[3]` pressed on the same cycle → `press` = 4'b1001 in one cycle.
- `rstn` pulsed low at `cnt`=2 during a press → all outputs 0 immediately, no pulse. Button still held → press 6 edges after `rstn` rises.

Source files
------------

// File: rtl/buttons_debounce_pkg.sv
// Shared constants and types for the push-button debouncer.
// DEBOUNCE_CYCLES is the board default; DEBOUNCE_SIM keeps simulations short.
package buttons_pkg;

    localparam int CLK_HZ          = 12_000_000;
    localparam int DEBOUNCE_MS     = 10;
    localparam int DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int DEBOUNCE_SIM    = 4;

    // Per-button view handed from a cell to the top level
    typedef struct packed {
        logic state;
        logic press;
        logic rel;
        logic toggle;
    } btn_evt_t;

endpackage

// File: rtl/buttons_debounce_if.sv
// Button-side bundle: raw pins in, debounced level/pulses/toggle out.
interface buttons_debounce_if #(
    parameter int N = 4
);

    logic [N-1:0] btn_i;
    logic [N-1:0] state_o;
    logic [N-1:0] press_o;
    logic [N-1:0] release_o;
    logic [N-1:0] toggle_o;

    modport slave (
        input  btn_i,
        output state_o,
        output press_o,
        output release_o,
        output toggle_o
    );

    modport master (
        output btn_i,
        input  state_o,
        input  press_o,
        input  release_o,
        input  toggle_o
    );

endinterface

// File: rtl/buttons_debounce_cell.sv
// One button: two-flop synchronizer, stability counter, debounced level,
// registered press/release pulses and a toggle bit that flips on each press.
module debounce_cell
    import buttons_pkg::*;
#(
    parameter int DEBOUNCE   = DEBOUNCE_SIM,
    parameter int ACTIVE_LOW = 1
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     btn_i,
    output btn_evt_t evt_o
);

    localparam int             CW       = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE - 1);
    localparam logic           POL      = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic          lvl_s;
    logic          s0_q, s1_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          state_q, state_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          toggle_q, toggle_d;

    assign lvl_s = btn_i ^ POL;

    // Counter only advances while the synchronized level disagrees with state
    always_comb begin
        cnt_d     = cnt_q;
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        toggle_d  = toggle_q;
        if (s1_q == state_q) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            cnt_d     = {CW{1'b0}};
            state_d   = s1_q;
            press_d   = s1_q;
            release_d = ~s1_q;
            toggle_d  = toggle_q ^ s1_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Synchronizer and debounce state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s0_q      <= 1'b0;
            s1_q      <= 1'b0;
            cnt_q     <= {CW{1'b0}};
            state_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            toggle_q  <= 1'b0;
        end else begin
            s0_q      <= lvl_s;
            s1_q      <= s0_q;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
        end
    end

    assign evt_o = '{state: state_q, press: press_q, rel: release_q, toggle: toggle_q};

endmodule

// File: rtl/buttons_debounce.sv
// N independent debounce cells between the raw button pins and user logic.
module buttons_debounce
    import buttons_pkg::*;
#(
    parameter int N          = 4,
    parameter int DEBOUNCE   = DEBOUNCE_CYCLES,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    buttons_debounce_if.slave    btn_bus
);

    btn_evt_t     evt_s [N];
    logic [N-1:0] state_s, press_s, release_s, toggle_s;

    for (genvar i = 0; i < N; i++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE   (DEBOUNCE),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_cell (
            .clk   (clk),
            .rstn  (rstn),
            .btn_i (btn_bus.btn_i[i]),
            .evt_o (evt_s[i])
        );
    end

    // Repack per-cell records into per-signal vectors
    always_comb begin
        state_s   = {N{1'b0}};
        press_s   = {N{1'b0}};
        release_s = {N{1'b0}};
        toggle_s  = {N{1'b0}};
        for (int k = 0; k < N; k++) begin
            state_s[k]   = evt_s[k].state;
            press_s[k]   = evt_s[k].press;
            release_s[k] = evt_s[k].rel;
            toggle_s[k]  = evt_s[k].toggle;
        end
    end

    assign btn_bus.state_o   = state_s;
    assign btn_bus.press_o   = press_s;
    assign btn_bus.release_o = release_s;
    assign btn_bus.toggle_o  = toggle_s;

endmodule

// File: tb/tb_buttons_debounce.sv
// Directed bench for buttons_debounce with N=4, DEBOUNCE=4 (plus a DEBOUNCE=1 instance).
module tb_buttons_debounce;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic [3:0] seen;

    buttons_debounce_if #(.N(4)) bus  ();
    buttons_debounce_if #(.N(4)) bus1 ();

    buttons_debounce #(.N(4), .DEBOUNCE(4), .ACTIVE_LOW(1)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .btn_bus (bus)
    );

    buttons_debounce #(.N(4), .DEBOUNCE(1), .ACTIVE_LOW(1)) dut1 (
        .clk     (clk),
        .rstn    (rstn),
        .btn_bus (bus1)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {bus.state_o, bus.press_o, bus.release_o, bus.toggle_o};
    endfunction

    initial begin
        bus.btn_i  = 4'hF;
        bus1.btn_i = 4'hF;
        #2 rstn = 1'b0;
        #1 check_vec("rst_async", outs(), 16'h0000);
        repeat (3) tick();
        rstn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_vec("idle", outs(), 16'h0000);
        end

        // DEBOUNCE=1: three edges of latency
        bus1.btn_i = 4'b1110;
        tick(); tick();
        check_vec("d1_early", {12'h0, bus1.press_o}, 16'h0000);
        tick();
        check_vec("d1_press", {8'h0, bus1.state_o, bus1.press_o}, 16'h0011);
        tick();
        check_vec("d1_pulse_end", {12'h0, bus1.press_o}, 16'h0000);

        // Basic press / release on btn[0]
        bus.btn_i = 4'b1110;
        repeat (5) tick();
        check_vec("b0_early", {8'h0, bus.state_o, bus.press_o}, 16'h0000);
        tick();
        check_vec("b0_press", outs(), {4'b0001, 4'b0001, 4'b0000, 4'b0001});
        tick();
        check_vec("b0_press_end", {12'h0, bus.press_o}, 16'h0000);
        bus.btn_i = 4'b1111;
        repeat (5) tick();
        check_vec("b0_rel_early", {8'h0, bus.state_o, bus.release_o}, 16'h0010);
        tick();
        check_vec("b0_release", outs(), {4'b0000, 4'b0000, 4'b0001, 4'b0001});
        tick();
        check_vec("b0_rel_end", {12'h0, bus.release_o}, 16'h0000);

        // btn[1] low for 3 cycles: rejected
        bus.btn_i = 4'b1101;
        repeat (3) tick();
        bus.btn_i = 4'b1111;
        seen = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | bus.press_o | bus.state_o;
        end
        check_vec("b1_glitch", {12'h0, seen}, 16'h0000);

        // btn[1] low for 4 cycles: accepted
        bus.btn_i = 4'b1101;
        repeat (4) tick();
        bus.btn_i = 4'b1111;
        tick();
        check_vec("b1_early", {12'h0, bus.press_o}, 16'h0000);
        tick();
        check_vec("b1_press", {8'h0, bus.state_o, bus.press_o}, 16'h0022);
        repeat (10) tick();

        // Bounce on btn[2]: L L H L L H then steady L
        seen = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            bus.btn_i = (i == 2 || i == 5) ? 4'b1111 : 4'b1011;
            tick();
            seen = seen | bus.press_o;
        end
        bus.btn_i = 4'b1011;
        repeat (5) begin
            tick();
            seen = seen | bus.press_o;
        end
        check_vec("b2_bounce_quiet", {12'h0, seen}, 16'h0000);
        tick();
        check_vec("b2_press", {12'h0, bus.press_o}, 16'h0004);
        seen = 4'b0000;
        repeat (8) begin
            tick();
            seen = seen | bus.press_o;
        end
        check_vec("b2_single", {12'h0, seen}, 16'h0000);
        bus.btn_i = 4'b1111;
        repeat (10) tick();

        // Simultaneous press on btn[0] and btn[3]
        bus.btn_i = 4'b0110;
        repeat (6) tick();
        check_vec("b03_press", {4'h0, bus.state_o, bus.press_o, bus.toggle_o}, 16'h099E);

        // Reset mid-count while btn[2] is being pressed
        tick();
        bus.btn_i = 4'b0010;
        repeat (4) tick();
        rstn = 1'b0;
        #1 check_vec("rst_mid", outs(), 16'h0000);
        seen = 4'b0000;
        repeat (2) begin
            tick();
            seen = seen | bus.press_o | bus.state_o | bus.toggle_o;
        end
        check_vec("rst_hold", {12'h0, seen}, 16'h0000);
        rstn = 1'b1;
        repeat (5) begin
            tick();
            seen = seen | bus.press_o;
        end
        check_vec("post_rst_early", {12'h0, seen}, 16'h0000);
        tick();
        check_vec("post_rst_press", outs(), {4'b1101, 4'b1101, 4'b0000, 4'b1101});
        tick();
        check_vec("post_rst_end", {12'h0, bus.press_o}, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
